reg_writeback: RTL
==================

Name: reg_writeback

Overview:
- Writeback stage directly upstream of the register file. It merges ALU results and load results from the LSU onto the register file's single write port.
- ALU results have priority. Load results are buffered in a small FIFO and drained when the port is free or when the starvation guard fires.
- Also provides an operand read path with optional write-to-read forwarding, because the register file returns the old value when a register is read and written in the same cycle.

Parameters:
- DataWidth, 16, width of register data.
- NumRegs, 16, number of architectural registers.
- AddrWidth, $clog2(NumRegs), register address width.
- FifoDepth, 2, load-result FIFO entries; power of two, at least 2.
- StarveLimit, 4, maximum consecutive cycles the ALU may win while the FIFO is non-empty.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_addr  in  AddrWidth  ALU destination register.
- alu_data  in  DataWidth  ALU result.
- lsu_valid  in  1  load result available.
- lsu_ready  out  1  load result accepted into the FIFO.
- lsu_addr  in  AddrWidth  load destination register.
- lsu_data  in  DataWidth  load data.
- lsu_pending  out  1  FIFO non-empty; decode uses it to stall.
- wb_en  out  1  write enable to the register file (reg_w_en).
- wb_addr  out  AddrWidth  write address (addr_in).
- wb_data  out  DataWidth  write data (reg_in).
- rd_addr1, rd_addr2  in  AddrWidth  operand read addresses, also driven to the register file.
- rf_out1, rf_out2  in  DataWidth  raw register file read data.
- op1, op2  out  DataWidth  operand values delivered to execute.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wb_en=0, wb_addr=0, wb_data=0.
  - FIFO emptied (lsu_pending=0).
  - Starvation counter cleared.
  - Any in-flight result is discarded.
  - Outputs hold these values until the first rising edge after rst_n deasserts.
- Handshakes are valid/ready; a transfer occurs when both are high at the rising edge.
  - Producers must hold addr/data stable while valid is high and ready is low.
- lsu_ready = !full. There is no same-cycle bypass around the FIFO.
- Arbitration, evaluated each cycle:
  - FIFO empty: alu_ready=1; on alu_valid, the ALU result is selected.
  - FIFO non-empty, starve_cnt < StarveLimit, alu_valid=1: ALU selected, alu_ready=1, starve_cnt increments.
  - FIFO non-empty and (alu_valid=0 or starve_cnt==StarveLimit): FIFO head selected and popped, starve_cnt cleared, alu_ready=0 when starve_cnt==StarveLimit.
  - Nothing selected: wb_en=0 next cycle; wb_addr and wb_data hold their previous values.
- starve_cnt:
  - Saturates at StarveLimit.
  - Cleared when the FIFO is empty or on any FIFO pop.
- Output register: the selected result is registered into wb_en/wb_addr/wb_data.
  - ALU: handshake in cycle N gives wb_en=1 in cycle N+1, and the register file writes at the end of N+1.
  - LSU: handshake in cycle N gives wb_en=1 at the earliest in cycle N+2.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FifoDepth) bits that wrap naturally, plus an occupancy count of $clog2(FifoDepth)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - Writes retire in order per source; no reordering between loads.
- Same-destination conflict: an ALU result and a buffered load to the same register retire in arbitration order. Ordering is the scheduler's responsibility; decode stalls on lsu_pending.
- No special handling of register 0.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - op1 = (wb_en && wb_addr==rd_addr1) ? wb_data : rf_out1; op2 follows the same rule.
  - Purely combinational; no added latency.
- Undefined:
  - op1=rf_out1 and op2=rf_out2, pass-through.
  - Ports remain present.

Test Plan:
- Reset then idle: rst_n low mid-traffic with 2 FIFO entries -> wb_en=0 and lsu_pending=0 immediately; no write after release.
- ALU only: alu_valid with addr=3, data=0x1234 in cycle N -> wb_en=1, wb_addr=3, wb_data=0x1234 in N+1 only.
- LSU only: lsu_valid with addr=5, data=0xBEEF in cycle N -> lsu_pending=1 at N+1, wb_en with 5/0xBEEF at N+2, lsu_pending=0 at N+2.
- FIFO full: three back-to-back loads while alu_valid is held high -> lsu_ready=0 on the third; after 4 ALU wins, alu_ready=0 for one cycle and load 1 is written; then 4 more ALU wins before load 2.
- Simultaneous push/pop with FIFO at 1 entry and ALU idle -> count stays 1 and writes emerge in load order.
- WB_FORWARD_EN: wb_en=1, wb_addr=7, wb_data=0x00AA, rd_addr1=7, rf_out1=0x0011 -> op1=0x00AA. Without the macro -> op1=0x0011.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU results and buffered load results onto the single register file write port.
// Optional macro WB_FORWARD_EN enables write-to-read forwarding on the operand read path.
module reg_writeback #(
    parameter int DataWidth   = 16,
    parameter int NumRegs     = 16,
    parameter int AddrWidth   = $clog2(NumRegs),
    parameter int FifoDepth   = 2,
    parameter int StarveLimit = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AddrWidth-1:0] alu_addr,
    input  logic [DataWidth-1:0] alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [AddrWidth-1:0] lsu_addr,
    input  logic [DataWidth-1:0] lsu_data,
    output logic                 lsu_pending,
    output logic                 wb_en,
    output logic [AddrWidth-1:0] wb_addr,
    output logic [DataWidth-1:0] wb_data,
    input  logic [AddrWidth-1:0] rd_addr1,
    input  logic [AddrWidth-1:0] rd_addr2,
    input  logic [DataWidth-1:0] rf_out1,
    input  logic [DataWidth-1:0] rf_out2,
    output logic [DataWidth-1:0] op1,
    output logic [DataWidth-1:0] op2
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam int SW   = $clog2(StarveLimit + 1);

    logic [AddrWidth-1:0] fifo_addr [FifoDepth];
    logic [DataWidth-1:0] fifo_data [FifoDepth];
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic [CntW-1:0]      count;
    logic [SW-1:0]        starve_cnt;

    logic empty;
    logic full;
    logic starved;
    logic sel_alu;
    logic push;
    logic pop;

    assign empty   = (count == '0);
    assign full    = (count == CntW'(FifoDepth));
    assign starved = (starve_cnt == SW'(StarveLimit));

    // ALU wins unless loads are waiting and it has already won StarveLimit times in a row.
    assign alu_ready   = empty || !starved;
    assign lsu_ready   = !full;
    assign lsu_pending = !empty;

    assign sel_alu = alu_valid && alu_ready;
    assign push    = lsu_valid && lsu_ready;
    assign pop     = !empty && !sel_alu;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lsu_addr;
            fifo_data[wr_ptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (sel_alu && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Address and data hold their last value when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (sel_alu) begin
            wb_en   <= 1'b1;
            wb_addr <= alu_addr;
            wb_data <= alu_data;
        end else if (pop) begin
            wb_en   <= 1'b1;
            wb_addr <= fifo_addr[rd_ptr];
            wb_data <= fifo_data[rd_ptr];
        end else begin
            wb_en   <= 1'b0;
        end
    end

`ifdef WB_FORWARD_EN
    // The register file returns the old value on a same-cycle read/write, so bypass the write.
    assign op1 = (wb_en && (wb_addr == rd_addr1)) ? wb_data : rf_out1;
    assign op2 = (wb_en && (wb_addr == rd_addr2)) ? wb_data : rf_out2;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr1, rd_addr2};
    assign op1 = rf_out1;
    assign op2 = rf_out2;
`endif

endmodule
